conv_window_sequencer: RTL and testbench
========================================

# conv_window_sequencer

Sequencer that drives the kernel-memory lookup and the image-memory read port for a valid-mode 2-D convolution. On `start` it walks every output pixel position of an IMG_W x IMG_H image. For each position it walks all M x M kernel taps, emitting one kernel address plus the matching image address per tap. The block sits between the top-level control and the kernel/image memories, and feeds the MAC stage through a valid/ready handshake.

## Interface
- `M`, 3: kernel side length; M*M ≤ 128 so that `kaddr` fits in 7 bits.
- `IMG_W`, 8: image width in pixels; must be ≥ M.
- `IMG_H`, 8: image height in pixels; must be ≥ M.
- `IAW`, 12: image address width; 2^IAW ≥ IMG_W*IMG_H.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a pass; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of the current pass.
- `ready`  in  1  downstream MAC accepts the current tap.
- `tap_valid`  out  1  `kaddr`/`iaddr`/flags are valid.
- `kaddr`  out  7  kernel index, kr*M+kc.
- `iaddr`  out  IAW  image address, (orow+kr)*IMG_W + (ocol+kc).
- `first_tap`  out  1  tap is kr=0, kc=0 (MAC clears its accumulator).
- `last_tap`  out  1  tap is kr=M-1, kc=M-1 (MAC writes out its result).
- `orow`  out  8  output pixel row, 0..IMG_H-M.
- `ocol`  out  8  output pixel column, 0..IMG_W-M.
- `busy`  out  1  a pass is in progress.
- `done`  out  1  one-cycle pulse when a pass completes.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- Counters: `kc`, `kr`, `ocol`, `orow`. All outputs are registered.
- **IDLE**
  - `start`=1 clears all counters and moves to RUN.
  - `abort` has no effect.
- **RUN**
  - `tap_valid`=1 and `busy`=1.
  - A tap advances only when `tap_valid`&&`ready`.
  - Counters nest, innermost first: `kc`, `kr`, `ocol`, `orow`. Each counter wraps to 0 and carries into the next.
- **Leaving RUN**
  - When the tap with `orow`=IMG_H-M, `ocol`=IMG_W-M, `last_tap`=1 is accepted, the FSM moves to DONE.
  - `abort`=1 in RUN moves to IDLE on the next edge, regardless of `ready`. No `done` is produced and all counters clear.
- **DONE**
  - `done`=1, `busy`=0, `tap_valid`=0 for exactly one cycle, then IDLE.
  - `start` asserted while in DONE is ignored.
- **Handshake**
  - While `tap_valid`=1 and `ready`=0, all outputs hold stable.
  - `tap_valid` never drops in RUN except on `abort`.
- **Arithmetic**
  - `iaddr` is computed from the next-state counters and registered. No combinational path from counters to outputs.
  - Intermediate products are sized to IAW. Parameter legality guarantees no overflow.
- **Simultaneous events**
  - `abort` and acceptance of the final tap in the same cycle: `abort` wins, FSM goes to IDLE, no `done`.
  - `start` while busy is ignored.
- **Reset**
  - Asserting `rstn` at any time, including mid-pass, returns the FSM to IDLE immediately.
  - Reset values: all outputs 0 (`tap_valid`, `kaddr`, `iaddr`, flags, `orow`, `ocol`, `busy`, `done`), all counters 0.

## Timing
- Total taps per pass: N = (IMG_H-M+1)*(IMG_W-M+1)*M*M.
- `start` sampled at edge 0 → first tap presented in the cycle after edge 0 (`kaddr`=0, `iaddr`=0, `first_tap`=1).
- With `ready` held at 1, the last tap is accepted at edge N.
- `done` is high for the cycle after edge N; `busy` is high for cycles 1..N.
- Throughput: one tap per cycle with no bubbles between output pixels.
- Each cycle of `ready`=0 adds exactly one cycle to the pass.
- `abort` sampled at edge k → `tap_valid`=0 and `busy`=0 in the cycle after edge k.
- A new `start` is accepted one cycle after `done` (first IDLE cycle).

## Test plan
- **Basic pass**
  - Stimulus: IMG_W=IMG_H=4, M=3, `ready`=1, one `start` pulse.
  - Required response:
    - 36 taps, one per cycle, first tap `kaddr`=0, `iaddr`=0.
    - Tap 3 (kr=1, kc=0): `iaddr`=4.
    - Tap 8: `kaddr`=8, `iaddr`=10, `last_tap`=1.
    - Tap 9: `ocol`=1, `iaddr`=1, `first_tap`=1.
    - Final tap: `orow`=1, `ocol`=1, `iaddr`=15.
    - `done` pulses in the cycle after edge 36.
- **Backpressure**
  - Stimulus: same configuration, `ready` toggling 1,0,0,1…
  - Required response:
    - Outputs frozen while `ready`=0.
    - Accepted tap sequence identical to the basic pass.
    - `done` delayed by exactly the number of `ready`=0 cycles.
- **Abort**
  - Stimulus: `abort` asserted during tap 20, then a fresh `start`.
  - Required response:
    - `tap_valid`=0 and `busy`=0 on the next cycle, `done` never asserts.
    - The fresh `start` restarts at `kaddr`=0, `iaddr`=0.
- **Abort at final tap**
  - Stimulus: `abort` coincides with acceptance of the final tap.
  - Required response: no `done`, FSM returns to IDLE.
- **Start while busy / in DONE**
  - Stimulus: extra `start` pulses at tap 5 and in the DONE cycle.
  - Required response: both ignored, exactly one pass of 36 taps.
- **Asynchronous reset mid-pass**
  - Stimulus: `rstn` dropped between clock edges at tap 17.
  - Required response:
    - All outputs read 0 immediately, without waiting for a clock edge.
    - After release, no activity until the next `start`.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - kernel/image address sequencer for valid-mode 2-D convolution
// Walks every output pixel and all MxM taps of each, feeding the MAC through a valid/ready handshake.
module conv_window_sequencer #(
  parameter int M     = 3,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int IAW   = 12
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic           ready,
  output logic           tap_valid,
  output logic [6:0]     kaddr,
  output logic [IAW-1:0] iaddr,
  output logic           first_tap,
  output logic           last_tap,
  output logic [7:0]     orow,
  output logic [7:0]     ocol,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]     K_LAST   = 8'(M - 1);
  localparam logic [7:0]     COL_LAST = 8'(IMG_W - M);
  localparam logic [7:0]     ROW_LAST = 8'(IMG_H - M);
  localparam logic [IAW-1:0] ROW_PITCH = IAW'(IMG_W);

  state_t         state, state_n;
  logic [7:0]     kc, kr;
  logic [7:0]     kc_n, kr_n, ocol_n, orow_n;
  logic           final_tap;
  logic           advance;
  logic           run_n;
  logic [IAW-1:0] row_sum, col_sum;
  logic [6:0]     kaddr_n;
  logic [IAW-1:0] iaddr_n;
  logic           first_n, last_n;

  // orow/ocol outputs double as the two outer loop counters.
  assign final_tap = (kc == K_LAST) && (kr == K_LAST) &&
                     (ocol == COL_LAST) && (orow == ROW_LAST);
  assign advance   = (state == RUN) && ready;

  always_comb begin
    state_n = state;
    kc_n    = kc;
    kr_n    = kr;
    ocol_n  = ocol;
    orow_n  = orow;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          kc_n    = 8'd0;
          kr_n    = 8'd0;
          ocol_n  = 8'd0;
          orow_n  = 8'd0;
        end
      end
      RUN: begin
        if (abort || (advance && final_tap)) begin
          state_n = abort ? IDLE : DONE;
          kc_n    = 8'd0;
          kr_n    = 8'd0;
          ocol_n  = 8'd0;
          orow_n  = 8'd0;
        end else if (advance) begin
          if (kc == K_LAST) begin
            kc_n = 8'd0;
            if (kr == K_LAST) begin
              kr_n = 8'd0;
              if (ocol == COL_LAST) begin
                ocol_n = 8'd0;
                orow_n = orow + 8'd1;
              end else begin
                ocol_n = ocol + 8'd1;
              end
            end else begin
              kr_n = kr + 8'd1;
            end
          end else begin
            kc_n = kc + 8'd1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Tap outputs are derived from next-state counters so they register alongside them.
  always_comb begin
    run_n   = (state_n == RUN);
    row_sum = IAW'(orow_n) + IAW'(kr_n);
    col_sum = IAW'(ocol_n) + IAW'(kc_n);
    kaddr_n = run_n ? 7'(kr_n * M + kc_n) : 7'd0;
    iaddr_n = run_n ? (row_sum * ROW_PITCH + col_sum) : '0;
    first_n = run_n && (kr_n == 8'd0) && (kc_n == 8'd0);
    last_n  = run_n && (kr_n == K_LAST) && (kc_n == K_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      kc        <= 8'd0;
      kr        <= 8'd0;
      ocol      <= 8'd0;
      orow      <= 8'd0;
      tap_valid <= 1'b0;
      kaddr     <= 7'd0;
      iaddr     <= '0;
      first_tap <= 1'b0;
      last_tap  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      kc        <= kc_n;
      kr        <= kr_n;
      ocol      <= ocol_n;
      orow      <= orow_n;
      tap_valid <= run_n;
      kaddr     <= kaddr_n;
      iaddr     <= iaddr_n;
      first_tap <= first_n;
      last_tap  <= last_n;
      busy      <= run_n;
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - scoreboard bench for conv_window_sequencer
// 4x4 image, 3x3 kernel: 36 taps per pass.
module tb_conv_window_sequencer;

  localparam int M   = 3;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int IAW = 12;
  localparam int N   = 36;

  typedef struct packed {
    logic [6:0]     kaddr;
    logic [IAW-1:0] iaddr;
    logic           first;
    logic           last;
    logic [7:0]     orow;
    logic [7:0]     ocol;
  } tap_t;

  logic           clk = 1'b0;
  logic           rstn, start, abort, ready;
  logic           tap_valid, first_tap, last_tap, busy, done;
  logic [6:0]     kaddr;
  logic [IAW-1:0] iaddr;
  logic [7:0]     orow, ocol;

  conv_window_sequencer #(.M(M), .IMG_W(W), .IMG_H(H), .IAW(IAW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .ready(ready),
    .tap_valid(tap_valid), .kaddr(kaddr), .iaddr(iaddr),
    .first_tap(first_tap), .last_tap(last_tap), .orow(orow), .ocol(ocol),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   cyc = 0, c0 = 0;
  int   acc_cnt = 0, busy_cnt = 0, stall_cnt = 0, done_cnt = 0, tv_cnt = 0;
  int   ph = 0, d0 = 0, tv0 = 0;
  logic bp = 1'b0;
  logic hold_pend = 1'b0;
  tap_t cur, prev, exp_t;
  tap_t exp_q[$];
  tap_t log_q[64];
  logic [0:3] pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_pass();
    tap_t t;
    for (int r = 0; r <= H - M; r++)
      for (int c = 0; c <= W - M; c++)
        for (int i = 0; i < M; i++)
          for (int j = 0; j < M; j++) begin
            t.kaddr = 7'(i * M + j);
            t.iaddr = IAW'((r + i) * W + c + j);
            t.first = (i == 0) && (j == 0);
            t.last  = (i == M - 1) && (j == M - 1);
            t.orow  = 8'(r);
            t.ocol  = 8'(c);
            exp_q.push_back(t);
          end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bp) begin
      ready = pat[ph];
      ph = (ph + 1) % 4;
    end else begin
      ready = 1'b1;
    end
  end

  // Monitor: pops one expectation per accepted tap, and checks hold under backpressure.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (busy && !ready) stall_cnt++;
    if (done) done_cnt++;
    if (tap_valid) tv_cnt++;
    cur = {kaddr, iaddr, first_tap, last_tap, orow, ocol};
    if (tap_valid && hold_pend) check("hold_stable", 64'(cur), 64'(prev));
    hold_pend = tap_valid && !ready;
    prev = cur;
    if (tap_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tap actual=%0h required=none", cur);
      end else begin
        exp_t = exp_q.pop_front();
        check($sformatf("tap%0d", acc_cnt), 64'(cur), 64'(exp_t));
      end
      if (acc_cnt < 64) log_q[acc_cnt] = cur;
      acc_cnt++;
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    busy_cnt = 0;
    stall_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int b = 0;
    while (acc_cnt < n && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    check("wait_acc_bound", 64'(acc_cnt >= n), 64'd1);
  endtask

  task automatic wait_done();
    int b = 0;
    while (!done && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    check("wait_done_bound", 64'(done), 64'd1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("reset_outputs", 64'({tap_valid, kaddr, iaddr, first_tap, last_tap, orow, ocol, busy, done}), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Basic pass
    acc_cnt = 0; push_pass();
    do_start();
    check("first_tap_present", 64'({tap_valid, kaddr, iaddr, first_tap}), 64'({1'b1, 7'd0, 12'd0, 1'b1}));
    wait_done();
    check("basic_done_edge", 64'(cyc - c0), 64'(N));
    check("basic_taps", 64'(acc_cnt), 64'(N));
    check("basic_busy_cycles", 64'(busy_cnt), 64'(N));
    check("tap3_iaddr", 64'(log_q[3].iaddr), 64'd4);
    check("tap8", 64'({log_q[8].kaddr, log_q[8].iaddr, log_q[8].last}), 64'({7'd8, 12'd10, 1'b1}));
    check("tap9", 64'({log_q[9].ocol, log_q[9].iaddr, log_q[9].first}), 64'({8'd1, 12'd1, 1'b1}));
    check("tap35", 64'({log_q[35].orow, log_q[35].ocol, log_q[35].iaddr}), 64'({8'd1, 8'd1, 12'd15}));
    @(posedge clk); #1;
    check("done_one_cycle", 64'({done, busy, tap_valid}), 64'd0);

    // Backpressure
    acc_cnt = 0; push_pass();
    do_start();
    bp = 1'b1; ph = 1;
    wait_done();
    bp = 1'b0;
    check("bp_taps", 64'(acc_cnt), 64'(N));
    check("bp_stalls_seen", 64'(stall_cnt > 0), 64'd1);
    check("bp_done_edge", 64'(cyc - c0), 64'(N + stall_cnt));
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort during tap 20, then restart
    repeat (2) @(posedge clk);
    acc_cnt = 0; push_pass(); d0 = done_cnt;
    do_start();
    wait_acc(20);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_idle", 64'({tap_valid, busy}), 64'd0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    acc_cnt = 0; push_pass();
    do_start();
    check("restart_first_tap", 64'({tap_valid, kaddr, iaddr, first_tap}), 64'({1'b1, 7'd0, 12'd0, 1'b1}));
    wait_done();
    check("restart_done_edge", 64'(cyc - c0), 64'(N));

    // Abort coinciding with final tap acceptance
    repeat (2) @(posedge clk);
    acc_cnt = 0; push_pass(); d0 = done_cnt;
    do_start();
    wait_acc(N - 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("final_abort_idle", 64'({tap_valid, busy, done}), 64'd0);
    repeat (3) @(posedge clk);
    check("final_abort_no_done", 64'(done_cnt), 64'(d0));
    check("final_abort_taps", 64'(acc_cnt), 64'(N));

    // Start while busy and in DONE
    repeat (2) @(posedge clk);
    acc_cnt = 0; push_pass(); d0 = done_cnt;
    do_start();
    wait_acc(5);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("extra_start_taps", 64'(acc_cnt), 64'(N));
    check("extra_start_one_done", 64'(done_cnt), 64'(d0 + 1));
    check("extra_start_idle", 64'({tap_valid, busy}), 64'd0);

    // Asynchronous reset mid-pass
    acc_cnt = 0; push_pass();
    do_start();
    wait_acc(17);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_outputs", 64'({tap_valid, kaddr, iaddr, first_tap, last_tap, orow, ocol, busy, done}), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    exp_q.delete();
    tv0 = tv_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_quiet", 64'(tv_cnt), 64'(tv0));
    check("post_reset_idle", 64'({busy, done}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
